// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline boundary: two-entry skid buffer carrying the ALU result and
// control fields, with overflow trapping, halt/exception drain and a retire counter.
module ex_mem_skid #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_ofl,
    input  logic          alu_zero,
    input  logic [DW-1:0] in_store_data,
    input  logic [2:0]    in_wr_reg,
    input  logic          in_wr_en,
    input  logic          in_mem_rd,
    input  logic          in_mem_wr,
    input  logic          in_halt,
    input  logic          in_ofl_chk,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] out_store_data,
    output logic [2:0]    out_wr_reg,
    output logic          out_zero,
    output logic          out_wr_en,
    output logic          out_mem_rd,
    output logic          out_mem_wr,
    output logic          out_halt,
    output logic          exc_ofl,
    output logic          halted,
    output logic [15:0]   retired,
    output logic [1:0]    dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and ready here comes from flops only.

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DW-1:0] store_data;
        logic [2:0]    wr_reg;
        logic          wr_en;
        logic          mem_rd;
        logic          mem_wr;
        logic          halt;
        logic          zero;
        logic          exc;
    } pkt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;
    pkt_t   main_q, skid_q, in_pkt;
    logic   halted_q, halted_nxt;
    logic   accept, fire;
    logic   load_main, load_skid, main_from_skid;
    logic   main_v, skid_v;

    assign main_v    = (state != EMPTY);
    assign skid_v    = (state == TWO);
    assign in_ready  = ~skid_v & ~halted_q;
    assign out_valid = main_v;
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;
    assign dbg_state = state;

    always_comb begin
        in_pkt            = '0;
        in_pkt.data       = alu_out;
        in_pkt.store_data = in_store_data;
        in_pkt.wr_reg     = in_wr_reg;
        in_pkt.wr_en      = in_wr_en;
        in_pkt.mem_rd     = in_mem_rd;
        in_pkt.mem_wr     = in_mem_wr;
        in_pkt.halt       = in_halt;
        in_pkt.zero       = alu_zero;
        in_pkt.exc        = in_ofl_chk & alu_ofl;
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (fire) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (fire) begin
                    main_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase

        halted_nxt = halted_q | (accept & (in_pkt.halt | in_pkt.exc));

        // Flush wins over everything, including the packet offered this cycle.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
            halted_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            halted_q <= halted_nxt;
            if (load_main) begin
                main_q <= in_pkt;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_pkt;
            end
        end
    end

    // A fire during flush still counts: memory already took that packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (fire) begin
            retired <= retired + 16'd1;
        end
    end

    assign out_data       = main_q.data;
    assign out_store_data = main_q.store_data;
    assign out_wr_reg     = main_q.wr_reg;
    assign out_zero       = main_q.zero;
    assign out_wr_en      = main_q.wr_en & ~main_q.exc;
    assign out_mem_rd     = main_q.mem_rd & ~main_q.exc;
    assign out_mem_wr     = main_q.mem_wr & ~main_q.exc;
    assign out_halt       = main_q.halt;
    assign exc_ofl        = main_v & main_q.exc;
    assign halted         = halted_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: directed scenarios plus random traffic,
// scored against a capacity-2 FIFO reference model.
module tb_ex_mem_skid;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] alu_out = '0;
  logic          alu_ofl = 1'b0;
  logic          alu_zero = 1'b0;
  logic [DW-1:0] in_store_data = '0;
  logic [2:0]    in_wr_reg = '0;
  logic          in_wr_en = 1'b0;
  logic          in_mem_rd = 1'b0;
  logic          in_mem_wr = 1'b0;
  logic          in_halt = 1'b0;
  logic          in_ofl_chk = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [DW-1:0] out_store_data;
  logic [2:0]    out_wr_reg;
  logic          out_zero;
  logic          out_wr_en;
  logic          out_mem_rd;
  logic          out_mem_wr;
  logic          out_halt;
  logic          exc_ofl;
  logic          halted;
  logic [15:0]   retired;
  logic [1:0]    dbg_state;

  ex_mem_skid #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_zero(alu_zero),
    .in_store_data(in_store_data), .in_wr_reg(in_wr_reg), .in_wr_en(in_wr_en),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_halt(in_halt),
    .in_ofl_chk(in_ofl_chk),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_store_data(out_store_data), .out_wr_reg(out_wr_reg),
    .out_zero(out_zero), .out_wr_en(out_wr_en), .out_mem_rd(out_mem_rd),
    .out_mem_wr(out_mem_wr), .out_halt(out_halt),
    .exc_ofl(exc_ofl), .halted(halted), .retired(retired), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: expected memory-stage view of each buffered packet, oldest first
  // {data, store_data, wr_reg, zero, wr_en, mem_rd, mem_wr, halt, exc}
  logic [40:0] exp_q[$];
  logic        halted_m = 1'b0;
  logic [15:0] ret_m = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [40:0] cur_pkt();
    logic x;
    x = in_ofl_chk & alu_ofl;
    // Exception packets must not write registers or memory downstream.
    return {alu_out, in_store_data, in_wr_reg, alu_zero,
            in_wr_en & ~x, in_mem_rd & ~x, in_mem_wr & ~x, in_halt, x};
  endfunction

  task automatic compare_outputs();
    logic [40:0] h;
    check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    check("in_ready", 64'(in_ready), 64'((exp_q.size() < 2) && !halted_m));
    check("halted", 64'(halted), 64'(halted_m));
    check("retired", 64'(retired), 64'(ret_m));
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      check("head", 64'({out_data, out_store_data, out_wr_reg, out_zero,
                         out_wr_en, out_mem_rd, out_mem_wr, out_halt}), 64'(h[40:1]));
      check("exc_ofl", 64'(exc_ofl), 64'(h[0]));
    end else begin
      check("exc_ofl_idle", 64'(exc_ofl), 64'd0);
    end
  endtask

  // one clock: check, advance the model across the edge, settle
  task automatic cycle();
    logic        acc, fir;
    logic [40:0] p;
    compare_outputs();
    acc = in_valid && (exp_q.size() < 2) && !halted_m;
    fir = (exp_q.size() > 0) && out_ready;
    p = cur_pkt();
    @(posedge clk);
    if (fir) ret_m = ret_m + 16'd1;
    if (flush) begin
      exp_q.delete();
      halted_m = 1'b0;
    end else begin
      if (fir) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(p);
        if (p[1] || p[0]) halted_m = 1'b1;
      end
    end
    #1;
  endtask

  // driver tasks
  task automatic set_pkt(input logic v, input logic [15:0] d, input logic we,
                         input logic hlt, input logic chk, input logic ofl);
    in_valid      = v;
    alu_out       = d;
    in_wr_en      = we;
    in_halt       = hlt;
    in_ofl_chk    = chk;
    alu_ofl       = ofl;
    in_store_data = 16'($urandom);
    in_wr_reg     = 3'($urandom_range(0, 7));
    in_mem_rd     = 1'($urandom_range(0, 1));
    in_mem_wr     = 1'($urandom_range(0, 1));
    alu_zero      = (d == 16'd0);
  endtask

  task automatic idle_in();
    set_pkt(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle_in();
    flush = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_exc_ofl", 64'(exc_ofl), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    check("rst_fields", 64'({out_data, out_store_data, out_wr_reg, out_zero,
                             out_wr_en, out_mem_rd, out_mem_wr, out_halt}), 64'd0);
    exp_q.delete();
    halted_m = 1'b0;
    ret_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ret_snap;

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // streaming 1..8 with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      set_pkt(1'b1, 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      check("stream_latency", 64'(out_data), 64'(i));
    end
    idle_in();
    cycle();
    cycle();
    check("stream_retired", 64'(retired), 64'd8);

    // backpressure with 0xA, 0xB
    out_ready = 1'b0;
    set_pkt(1'b1, 16'h000A, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set_pkt(1'b1, 16'h000B, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    idle_in();
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    cycle();
    out_ready = 1'b1;
    check("bp_first", 64'(out_data), 64'h000A);
    cycle();
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    check("bp_second", 64'(out_data), 64'h000B);
    cycle();

    // overflow trap then flush
    out_ready = 1'b0;
    set_pkt(1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    idle_in();
    check("trap_exc_ofl", 64'(exc_ofl), 64'd1);
    check("trap_wr_en", 64'(out_wr_en), 64'd0);
    check("trap_halted", 64'(halted), 64'd1);
    in_valid = 1'b1;
    cycle();
    check("trap_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle_in();
    check("trap_flush_empty", 64'(out_valid), 64'd0);
    check("trap_flush_ready", 64'(in_ready), 64'd1);

    // HALT drain under stall, then stray inputs ignored
    set_pkt(1'b1, 16'h0101, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set_pkt(1'b1, 16'h0202, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set_pkt(1'b1, 16'h0303, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 6; i++) begin
      set_pkt(1'(i % 2), 16'(i + 16'h0400), 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    check("halt_stays", 64'(halted), 64'd1);
    flush = 1'b1;
    idle_in();
    cycle();
    flush = 1'b0;

    // flush in TWO with a simultaneous fire
    out_ready = 1'b0;
    set_pkt(1'b1, 16'h0C01, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set_pkt(1'b1, 16'h0C02, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    idle_in();
    ret_snap = retired;
    flush = 1'b1;
    out_ready = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_two_valid", 64'(out_valid), 64'd0);
    check("flush_two_retired", 64'(retired), 64'(ret_snap + 16'd1));

    // reset mid-stall with TWO full
    out_ready = 1'b0;
    set_pkt(1'b1, 16'h0D01, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set_pkt(1'b1, 16'h0D02, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    do_reset();

    // retired wraps: 65535 fires reach FFFF, one more wraps to 0
    out_ready = 1'b1;
    set_pkt(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65536; i++) cycle();
    check("wrap_ffff", 64'(retired), 64'hFFFF);
    idle_in();
    cycle();
    check("wrap_zero", 64'(retired), 64'd0);
    cycle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      set_pkt(1'($urandom_range(0, 3) != 0), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 30) == 0);
      cycle();
    end
    flush = 1'b0;
    idle_in();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
# ex_mem_skid

Pipeline boundary between the execute stage (16-bit ALU) and the memory stage. It captures the ALU result (`Out`, `OFL`, `Zero`) together with the instruction's control fields into a two-entry skid buffer with a valid/ready handshake. Memory-stage stalls therefore never create a combinational ready path back into execute. It also qualifies signed-overflow exceptions, latches halt and exception drain state, and counts retired packets.

## Interface
- `DW`, 16: ALU data width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of all buffered packets and drain state.
- `in_valid` input 1: execute stage presents a packet.
- `in_ready` output 1: buffer can accept; driven from registers only.
- `alu_out` input DW: ALU result.
- `alu_ofl` input 1: ALU overflow flag.
- `alu_zero` input 1: ALU zero flag.
- `in_store_data` input DW: register data for stores.
- `in_wr_reg` input 3: destination register.
- `in_wr_en` input 1: register writeback enable.
- `in_mem_rd` input 1: load.
- `in_mem_wr` input 1: store.
- `in_halt` input 1: HALT instruction.
- `in_ofl_chk` input 1: instruction traps on overflow.
- `out_valid` output 1: packet available to memory stage.
- `out_ready` input 1: memory stage consumes.
- `out_data`, `out_store_data` output DW: registered copies of the input fields.
- `out_wr_reg` output 3: registered copy of the input field.
- `out_zero` output 1: registered copy of the input field.
- `out_wr_en`, `out_mem_rd`, `out_mem_wr` output 1: registered, but forced 0 when the packet has its exception bit set.
- `out_halt` output 1: packet is HALT.
- `exc_ofl` output 1: head packet carries an overflow exception; equals `out_valid & exc`.
- `halted` output 1: drain state is active.
- `retired` output 16: count of packets consumed.

## Operation
- Each packet holds 41 bits: data, store_data, wr_reg, wr_en, mem_rd, mem_wr, halt, zero, and `exc`.
  - `exc` is computed at capture as `in_ofl_chk & alu_ofl`.
- Storage consists of a main register (`main_v`) and a skid register (`skid_v`). Outputs always come from main.
- Occupancy states are EMPTY, ONE and TWO.
- `in_ready = ~skid_v & ~halted`. Accept means `in_valid & in_ready`; fire means `out_valid & out_ready`.
- Transitions:
  - EMPTY: accept loads main and moves to ONE.
  - ONE:
    - accept and fire: main takes the input; stay in ONE.
    - accept only: skid takes the input; move to TWO.
    - fire only: move to EMPTY.
    - neither: hold.
  - TWO: fire moves skid into main and goes to ONE. No accept is possible because `in_ready` is 0.
  - Packet order is strictly preserved.
- Drain state:
  - `halted` sets on the cycle a packet with halt=1 or exc=1 is accepted, and remains set.
  - Packets already buffered still drain normally.
  - `halted` clears only on `flush` or reset.
- `retired` increments on every fire and wraps from 16'hFFFF to 0.
- `flush` has highest priority:
  - Next state is EMPTY, `halted` is 0, and the input offered in the same cycle is discarded.
  - A fire in the flush cycle still counts toward `retired`, since the memory stage has already taken the packet.
- Reset mid-operation asynchronously clears all state regardless of handshake.

## Timing
- Reset values:
  - `out_valid` 0, `in_ready` 1, `halted` 0, `exc_ofl` 0, `retired` 0.
  - All `out_*` data and control fields are 0.
- Latency is 1 cycle: a packet accepted at edge N appears on `out_*` after edge N when the buffer was EMPTY, or ONE with a simultaneous fire.
- Throughput is 1 packet/cycle while `out_ready` stays high.
- `in_ready` falls the cycle after a stall fills skid, and rises the cycle after the next fire.
- Outputs are stable while `out_valid & ~out_ready`.
- There is no combinational path from any input to `in_ready` or `out_*`.

## Test plan
- Streaming: 8 back-to-back packets with `alu_out` = 1..8 and `out_ready` tied high -> output 1..8 on consecutive cycles, 1-cycle latency, `retired` = 8.
- Backpressure: `out_ready`=0 while packets 0xA and 0xB are sent -> `in_ready` drops after 0xB. Then raise `out_ready` -> 0xA then 0xB emerge; `in_ready` returns 1 the cycle after the first fire.
- Overflow trap:
  - Stimulus: `in_ofl_chk`=1, `alu_ofl`=1, `alu_out`=0x8000, wr_en=1.
  - Required: `exc_ofl`=1, `out_wr_en`=0, `halted`=1, `in_ready` held 0.
  - Follow-up: `flush` -> EMPTY and `in_ready`=1 next cycle.
- HALT drain: two normal packets followed by a HALT under stall -> all three drain in order, `out_halt`=1 on the third, and further `in_valid` is ignored.
- Flush in TWO with simultaneous fire -> `out_valid`=0 next cycle and `retired` increments by exactly 1.
- Reset: assert `rst_n`=0 mid-stall with TWO full -> outputs zero immediately. Also preload `retired`=0xFFFF and fire once -> `retired` = 0.
